// File: rtl/bus_slot_sched_pkg.sv
// Shared owner encoding and slot indices for the 64-cycle bus character period.
package bus_pkg;

    typedef enum logic [2:0] {
        NONE,
        CPU,
        VRAM,
        VROM,
        SPI
    } owner_t;

    localparam logic [1:0] SLOT_CPU   = 2'd0;
    localparam logic [1:0] SLOT_VRAM  = 2'd1;
    localparam logic [1:0] SLOT_VROM  = 2'd2;
    localparam logic [1:0] SLOT_SPARE = 2'd3;

endpackage

// File: rtl/bus_slot_sched_if.sv
// Bus-side signals of the slot scheduler: requests in, owner/strobes/handshake out.
interface bus_slot_sched_if;
    import bus_pkg::*;

    logic   video_en;
    logic   cpu_we;
    logic   spi_req;
    logic   spi_we;
    owner_t bus_owner;
    logic   ram_oe;
    logic   ram_we;
    logic   cpu_clk;
    logic   video_ram_clk;
    logic   video_rom_clk;
    logic   pixel_en;
    logic   char_strobe;
    logic   spi_grant;
    logic   spi_ack;

    modport slave (
        input  video_en, cpu_we, spi_req, spi_we,
        output bus_owner, ram_oe, ram_we, cpu_clk, video_ram_clk, video_rom_clk,
               pixel_en, char_strobe, spi_grant, spi_ack
    );

    modport master (
        output video_en, cpu_we, spi_req, spi_we,
        input  bus_owner, ram_oe, ram_we, cpu_clk, video_ram_clk, video_rom_clk,
               pixel_en, char_strobe, spi_grant, spi_ack
    );

endinterface

// File: rtl/bus_slot_sched.sv
// Four-slot time-division scheduler for the shared SRAM bus; every output is registered
// from the next-cycle counter value so strobe edges land exactly on SETUP and LATCH.
module bus_slot_sched
    import bus_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 16,
    parameter int unsigned SETUP       = 2,
    parameter int unsigned LATCH       = 14
) (
    input  logic            clk_i,
    input  logic            reset_i,
    bus_slot_sched_if.slave bus
);

    localparam int unsigned OffW = $clog2(SLOT_CYCLES);
    localparam int unsigned CycW = OffW + 2;

    logic [CycW-1:0] r_cyc;
    owner_t          r_owner;
    logic            r_wr;
    logic            r_pending;
    logic            r_ram_oe;
    logic            r_ram_we;
    logic            r_cpu_clk;
    logic            r_vram_clk;
    logic            r_vrom_clk;
    logic            r_pixel_en;
    logic            r_char_strobe;
    logic            r_spi_grant;
    logic            r_spi_ack;

    logic [CycW-1:0] w_cyc_nxt;
    logic [1:0]      w_slot;
    logic [OffW-1:0] w_off;
    logic [OffW-1:0] w_off_nxt;
    logic            w_window_nxt;
    logic            w_to_spare;
    logic            w_ack_nxt;
    owner_t          w_owner_nxt;
    logic            w_wr_nxt;

    assign w_cyc_nxt    = r_cyc + 1'b1;
    assign w_slot       = r_cyc[CycW-1 -: 2];
    assign w_off        = r_cyc[OffW-1:0];
    assign w_off_nxt    = w_cyc_nxt[OffW-1:0];
    assign w_window_nxt = (w_off_nxt >= OffW'(SETUP)) && (w_off_nxt < OffW'(LATCH));
    assign w_ack_nxt    = (w_owner_nxt == SPI) && (w_off_nxt == OffW'(LATCH));

    // Ownership and write direction are latched once per slot at offset 0.
    always_comb begin
        w_owner_nxt = r_owner;
        w_wr_nxt    = r_wr;
        w_to_spare  = 1'b0;
        if (w_off == '0) begin
            w_owner_nxt = NONE;
            w_wr_nxt    = 1'b0;
            unique case (w_slot)
                SLOT_CPU: begin
                    w_owner_nxt = CPU;
                    w_wr_nxt    = bus.cpu_we;
                end
                SLOT_VRAM: begin
                    if (bus.video_en) w_owner_nxt = VRAM;
                    else              w_to_spare  = 1'b1;
                end
                SLOT_VROM: begin
                    if (bus.video_en) w_owner_nxt = VROM;
                    else              w_to_spare  = 1'b1;
                end
                SLOT_SPARE: w_to_spare = 1'b1;
            endcase
            if (w_to_spare && bus.spi_req && !r_pending) begin
                w_owner_nxt = SPI;
                w_wr_nxt    = bus.spi_we;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cyc         <= '0;
            r_owner       <= NONE;
            r_wr          <= 1'b0;
            r_pending     <= 1'b0;
            r_ram_oe      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_cpu_clk     <= 1'b0;
            r_vram_clk    <= 1'b0;
            r_vrom_clk    <= 1'b0;
            r_pixel_en    <= 1'b0;
            r_char_strobe <= 1'b0;
            r_spi_grant   <= 1'b0;
            r_spi_ack     <= 1'b0;
        end else begin
            r_cyc         <= w_cyc_nxt;
            r_owner       <= w_owner_nxt;
            r_wr          <= w_wr_nxt;
            r_ram_oe      <= w_window_nxt && (w_owner_nxt != NONE) && !w_wr_nxt;
            r_ram_we      <= w_window_nxt && (w_owner_nxt != NONE) && w_wr_nxt;
            r_cpu_clk     <= w_window_nxt && (w_owner_nxt == CPU);
            r_vram_clk    <= w_window_nxt && (w_owner_nxt == VRAM);
            r_vrom_clk    <= w_window_nxt && (w_owner_nxt == VROM);
            r_pixel_en    <= (w_cyc_nxt[2:0] == 3'd7);
            r_char_strobe <= &w_cyc_nxt;
            r_spi_grant   <= (w_owner_nxt == SPI);
            r_spi_ack     <= w_ack_nxt;
            // A grant stays pending until its ack; a reset abandons it.
            if (w_off == '0 && w_owner_nxt == SPI) r_pending <= 1'b1;
            else if (w_ack_nxt)                    r_pending <= 1'b0;
        end
    end

    assign bus.bus_owner     = r_owner;
    assign bus.ram_oe        = r_ram_oe;
    assign bus.ram_we        = r_ram_we;
    assign bus.cpu_clk       = r_cpu_clk;
    assign bus.video_ram_clk = r_vram_clk;
    assign bus.video_rom_clk = r_vrom_clk;
    assign bus.pixel_en      = r_pixel_en;
    assign bus.char_strobe   = r_char_strobe;
    assign bus.spi_grant     = r_spi_grant;
    assign bus.spi_ack       = r_spi_ack;

endmodule

// File: tb/tb_bus_slot_sched.sv
// Directed bench for bus_slot_sched: whole character periods checked cycle by cycle.
module tb_bus_slot_sched;
    import bus_pkg::*;

    logic   clk = 1'b0;
    logic   reset_i;
    int     n_total = 0;
    int     n_bad   = 0;
    owner_t prev_own;

    bus_slot_sched_if bus_if ();

    bus_slot_sched #(
        .SLOT_CYCLES(16),
        .SETUP      (2),
        .LATCH      (14)
    ) u_dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":owner"}, int'(bus_if.bus_owner), int'(NONE));
        check({tag, ":outs"}, int'({bus_if.ram_oe, bus_if.ram_we, bus_if.cpu_clk,
                                    bus_if.video_ram_clk, bus_if.video_rom_clk,
                                    bus_if.pixel_en, bus_if.char_strobe,
                                    bus_if.spi_grant, bus_if.spi_ack}), 0);
    endtask

    function automatic owner_t slot_owner(input int s, input logic ven, input logic [3:0] gmask);
        if (s == 0) return CPU;
        if (ven && s == 1) return VRAM;
        if (ven && s == 2) return VROM;
        return gmask[s] ? SPI : NONE;
    endfunction

    // One 64-cycle period starting at cyc=0. gmask lists the slots expected to be granted to
    // SPI; req is high for cycles [req_lo, req_hi). Reset is asserted after cycle abort_at.
    task automatic run_period(input logic ven, input logic cwe, input logic swe,
                              input int req_lo, input int req_hi, input logic [3:0] gmask,
                              input int abort_at);
        for (int c = 0; c < 64; c++) begin
            int     s;
            int     off;
            owner_t cur;
            owner_t own;
            logic   win;
            logic   wr;
            s   = c / 16;
            off = c % 16;
            cur = slot_owner(s, ven, gmask);
            if (off != 0)    own = cur;
            else if (s == 0) own = prev_own;
            else             own = slot_owner(s - 1, ven, gmask);
            win = (off >= 2) && (off < 14);
            wr  = (s == 0) ? cwe : ((cur == SPI) ? swe : 1'b0);
            check($sformatf("owner@%0d", c), int'(bus_if.bus_owner), int'(own));
            check($sformatf("cpu_clk@%0d", c), int'(bus_if.cpu_clk), int'(win && cur == CPU));
            check($sformatf("vram_clk@%0d", c), int'(bus_if.video_ram_clk),
                  int'(win && cur == VRAM));
            check($sformatf("vrom_clk@%0d", c), int'(bus_if.video_rom_clk),
                  int'(win && cur == VROM));
            check($sformatf("ram_oe@%0d", c), int'(bus_if.ram_oe), int'(win && cur != NONE && !wr));
            check($sformatf("ram_we@%0d", c), int'(bus_if.ram_we), int'(win && cur != NONE && wr));
            check($sformatf("grant@%0d", c), int'(bus_if.spi_grant), int'(own == SPI));
            check($sformatf("ack@%0d", c), int'(bus_if.spi_ack), int'(off == 14 && cur == SPI));
            check($sformatf("pixel_en@%0d", c), int'(bus_if.pixel_en), int'((c % 8) == 7));
            check($sformatf("char@%0d", c), int'(bus_if.char_strobe), int'(c == 63));
            bus_if.video_en = ven;
            bus_if.cpu_we   = cwe;
            bus_if.spi_we   = swe;
            bus_if.spi_req  = (c >= req_lo) && (c < req_hi);
            if (c == abort_at) begin
                reset_i = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        prev_own = slot_owner(3, ven, gmask);
    endtask

    initial begin
        reset_i         = 1'b1;
        bus_if.video_en = 1'b0;
        bus_if.cpu_we   = 1'b0;
        bus_if.spi_req  = 1'b0;
        bus_if.spi_we   = 1'b0;
        prev_own        = NONE;

        repeat (5) begin
            @(negedge clk);
            check_idle("reset");
        end
        reset_i = 1'b0;

        // Video on, CPU read, no spare traffic.
        run_period(1'b1, 1'b0, 1'b0, 0, 0, 4'b0000, 64);
        // CPU write in slot 0; SPI write request raised at 40, dropped at 63.
        run_period(1'b1, 1'b1, 1'b1, 40, 63, 4'b1000, 64);
        // No request left: no grant; CPU back to read.
        run_period(1'b1, 1'b0, 1'b0, 0, 0, 4'b0000, 64);
        // Video off, request held: SPI reads in slots 1..3, then writes.
        run_period(1'b0, 1'b0, 1'b0, 0, 64, 4'b1110, 64);
        run_period(1'b0, 1'b0, 1'b1, 0, 64, 4'b1110, 64);
        // Reset at cycle 25, in the middle of an SPI slot-1 access.
        run_period(1'b0, 1'b0, 1'b0, 0, 64, 4'b1110, 25);
        check_idle("abort0");
        bus_if.spi_req = 1'b0;
        @(negedge clk);
        check_idle("abort1");
        reset_i  = 1'b0;
        prev_own = NONE;
        run_period(1'b1, 1'b0, 1'b0, 0, 0, 4'b0000, 64);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
